// File: rtl/alu_unit.sv
// alu_unit: registered integer ALU, one result per valid cycle, latency 1.
// Operands are zero-extended to 2*WIDTH bits, and one opcode is decoded
// combinationally. The result is captured in a single output register that
// holds until the next valid operation.
module alu_unit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           sel,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 valid,
    output logic [2*WIDTH-1:0]   c
);

    localparam int CW = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    logic [CW-1:0]    a_ext;
    logic [CW-1:0]    b_ext;
    logic [CW-1:0]    res;
    logic [CW-1:0]    c_d;
    logic [CW-1:0]    c_q;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;

    assign a_ext = {{WIDTH{1'b0}}, a};
    assign b_ext = {{WIDTH{1'b0}}, b};

    // Unrolled restoring division. The partial remainder is one bit wider
    // than b, so the shifted value (always < 2*b) never overflows.
    always_comb begin
        rem = '0;
        quo = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem = {rem[WIDTH-1:0], a[i]};
            if (rem >= {1'b0, b}) begin
                rem    = rem - {1'b0, b};
                quo[i] = 1'b1;
            end
        end
    end

    // Opcode decode. All eight codes are defined, so no X can escape.
    always_comb begin
        res = '0;
        case (op_e'(sel))
            OP_ADD: res = a_ext + b_ext;
            OP_SUB: res = a_ext - b_ext;
            OP_MUL: res = a_ext * b_ext;
            OP_DIV: res = (b == '0) ? {CW{1'b1}} : {rem[WIDTH-1:0], quo};
            OP_AND: res = a_ext & b_ext;
            OP_OR:  res = a_ext | b_ext;
            OP_XOR: res = a_ext ^ b_ext;
            OP_CMP: res = {{(CW-3){1'b0}}, (a > b), (a < b), (a == b)};
            default: res = '0;
        endcase
    end

    // Next result: load on valid, otherwise hold.
    always_comb begin
        c_d = c_q;
        if (valid) begin
            c_d = res;
        end
    end

    // Output register. Reset takes priority and discards a valid op.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed cases with known answers, followed by randomized
// reset/valid/sel/a/b stimulus. Each result is compared with an
// arithmetic reference model.
module tb_alu_unit;

    localparam int W  = 4;
    localparam int CW = 2 * W;
    localparam int MASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    sel = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          valid = 1'b0;
    logic [CW-1:0] c;

    int checks = 0;
    int errors = 0;
    int exp_c  = 0;

    alu_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .a     (a),
        .b     (b),
        .valid (valid),
        .c     (c)
    );

    always #5 clk = ~clk;

    // Compare an observed value with its expected value and count the comparison.
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result for one operation, computed with integer arithmetic.
    function automatic int ref_op(input int op, input int x, input int y);
        case (op)
            0: return (x + y) & MASK;
            1: return (x - y) & MASK;
            2: return (x * y) & MASK;
            3: return (y == 0) ? MASK : (((x % y) << W) | (x / y));
            4: return x & y;
            5: return x | y;
            6: return x ^ y;
            default: return ((x == y) ? 1 : 0) | ((x < y) ? 2 : 0) | ((x > y) ? 4 : 0);
        endcase
    endfunction

    // Drive one cycle on the falling edge. Then update the model and sample #1
    // after the rising edge.
    task automatic step(input bit r, input bit v, input int op, input int x, input int y,
                        input string tag);
        @(negedge clk);
        reset = r;
        valid = v;
        sel   = op[2:0];
        a     = x[W-1:0];
        b     = y[W-1:0];
        @(posedge clk);
        if (r)      exp_c = 0;
        else if (v) exp_c = ref_op(op, x, y);
        #1;
        chk(tag, int'(c), exp_c);
    endtask

    // Run one valid operation, then compare with both the model and a known constant.
    task automatic op_known(input int op, input int x, input int y, input int k, input string tag);
        step(1'b0, 1'b1, op, x, y, tag);
        chk({tag, "_const"}, int'(c), k);
    endtask

    initial begin
        // Reset held for three cycles while a valid ADD is presented.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 0, 15, 15, "reset_hold");
            chk("reset_zero", int'(c), 0);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 0, 15, 15, "post_reset_idle");
            chk("post_reset_zero", int'(c), 0);
        end

        op_known(0, 15, 15, 8'h1E, "add_15_15");
        op_known(1, 3, 5,   8'hFE, "sub_wrap");
        op_known(1, 9, 4,   8'h05, "sub_9_4");
        op_known(2, 15, 15, 8'hE1, "mul_15_15");
        op_known(2, 0, 7,   8'h00, "mul_0_7");
        op_known(3, 13, 4,  8'h13, "div_13_4");
        op_known(3, 7, 0,   8'hFF, "div_by_zero");
        op_known(4, 12, 10, 8'h08, "and");
        op_known(5, 12, 10, 8'h0E, "or");
        op_known(6, 12, 10, 8'h06, "xor");
        op_known(7, 2, 9,   8'h02, "cmp_lt");
        op_known(7, 5, 5,   8'h01, "cmp_eq");
        op_known(7, 9, 2,   8'h04, "cmp_gt");
        op_known(3, 15, 1,  8'h0F, "div_by_one");

        // Hold: the inputs toggle while valid is low.
        op_known(0, 1, 1, 8'h02, "hold_setup");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), "hold");
            chk("hold_const", int'(c), 8'h02);
        end

        // Mid-run reset.
        step(1'b1, 1'b1, 2, 15, 15, "midrun_reset");
        chk("midrun_reset_const", int'(c), 0);

        // Exhaustive DIV sweep against the model.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                step(1'b0, 1'b1, 3, x, y, "div_sweep");

        // Constrained-random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
